obi2ahb_master: RTL and testbench

Bridges one CV32E40P OBI-style data (or instruction) port onto an AHB-Lite master port feeding `mem_ahb` through the `top_m2s1` interconnect. The bridge accepts one request at a time and, when a request's byte-enable pattern is not a legal single AHB transfer, splits it into pipelined single transfers. It merges read lanes into one `rdata_o` response and reports AHB ERROR responses on `err_o`.

---
 rtl/obi2ahb_master_if.sv | 34 +++
 rtl/obi2ahb_master.sv | 175 +++++++++++++++++
 tb/tb_obi2ahb_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/obi2ahb_master_if.sv
// OBI request/response port plus AHB-Lite master port of obi2ahb_master.
// The master modport is the bridge's view; slave is the environment's view.
interface obi2ahb_master_if;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic [1:0]  HRESP;
   logic        HREADY;

   modport master (
      input  req_i, addr_i, we_i, be_i, wdata_i, HRDATA, HRESP, HREADY,
      output gnt_o, rvalid_o, rdata_o, err_o,
             HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
   );

   modport slave (
      output req_i, addr_i, we_i, be_i, wdata_i, HRDATA, HRESP, HREADY,
      input  gnt_o, rvalid_o, rdata_o, err_o,
             HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
   );
endinterface

// File: rtl/obi2ahb_master.sv
// OBI to AHB-Lite master bridge: one request at a time, illegal byte-enable
// patterns split into pipelined single byte transfers, read lanes merged.
module obi2ahb_master #(
   parameter int unsigned P_MST_ID = 0
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   obi2ahb_master_if.master  bus
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_DATA, S_DATA, S_ERR} state_t;
   typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_NONSEQ = 2'b10} htrans_t;

   function automatic logic [3:0] low_bit(input logic [3:0] m);
      return m & (~m + 4'd1);
   endfunction

   function automatic logic is_single(input logic [3:0] be);
      return (be == 4'hF) || (be == 4'h3) || (be == 4'hC) ||
             ((be != 4'h0) && ((be & (be - 4'd1)) == 4'h0));
   endfunction

   function automatic logic [1:0] lane_off(input logic [3:0] lanes);
      if (lanes[0])      return 2'd0;
      else if (lanes[1]) return 2'd1;
      else if (lanes[2]) return 2'd2;
      else               return 2'd3;
   endfunction

   function automatic logic [2:0] lane_size(input logic [3:0] lanes);
      if (lanes == 4'hF)                       return 3'b010;
      else if (lanes == 4'h3 || lanes == 4'hC) return 3'b001;
      else                                     return 3'b000;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
      logic [31:0] m;
      for (int unsigned i = 0; i < 4; i++) m[8*i +: 8] = {8{lanes[i]}};
      return m;
   endfunction

   state_t      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic        we_q, we_d, split_q, split_d, errf_q, errf_d;
   logic [3:0]  rem_q, rem_d, alanes_q, alanes_d, dlanes_q, dlanes_d;
   logic [31:0] wdata_q, wdata_d, acc_q, acc_d;
   logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, rdata_q, rdata_d;
   htrans_t     htrans_q, htrans_d;
   logic        hwrite_q, hwrite_d, rvalid_q, rvalid_d, err_q, err_d;
   logic [2:0]  hsize_q, hsize_d;

   logic [3:0]  lanes0, nlanes;
   logic        cap_split, resp_ok;
   logic [31:0] merged;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^bus.addr_i[1:0];
   assign cap_split = !is_single(bus.be_i);
   assign lanes0    = cap_split ? low_bit(bus.be_i) : bus.be_i;
   assign nlanes    = split_q ? low_bit(rem_q) : rem_q;
   assign resp_ok   = (bus.HRESP == 2'b00);
   assign merged    = we_q ? acc_q : (acc_q | (bus.HRDATA & lane_mask(dlanes_q)));

   always_comb begin
      state_d  = state_q;   addr_d   = addr_q;   we_d     = we_q;
      split_d  = split_q;   rem_d    = rem_q;    alanes_d = alanes_q;
      dlanes_d = dlanes_q;  wdata_d  = wdata_q;  acc_d    = acc_q;
      errf_d   = errf_q;    haddr_d  = haddr_q;  htrans_d = htrans_q;
      hwrite_d = hwrite_q;  hsize_d  = hsize_q;  hwdata_d = hwdata_q;
      rvalid_d = 1'b0;      rdata_d  = rdata_q;  err_d    = err_q;
      case (state_q)
         S_IDLE: if (bus.req_i) begin
            addr_d  = bus.addr_i[31:2];
            we_d    = bus.we_i;
            wdata_d = bus.wdata_i;
            split_d = cap_split;
            acc_d   = '0;
            errf_d  = 1'b0;
            if (bus.be_i == 4'h0) begin
               rvalid_d = 1'b1;
               rdata_d  = '0;
               err_d    = 1'b0;
            end else begin
               rem_d    = bus.be_i & ~lanes0;
               alanes_d = lanes0;
               haddr_d  = {bus.addr_i[31:2], lane_off(lanes0)};
               hsize_d  = lane_size(lanes0);
               hwrite_d = bus.we_i;
               htrans_d = HT_NONSEQ;
               state_d  = S_ADDR;
            end
         end
         S_ADDR, S_ADDR_DATA: begin
            if (bus.HREADY) begin
               // An ERROR with no preceding wait cycle still lets the rest complete.
               if (state_q == S_ADDR_DATA) begin
                  if (resp_ok) acc_d  = merged;
                  else         errf_d = 1'b1;
               end
               dlanes_d = alanes_q;
               hwdata_d = wdata_q;
               if (rem_q != 4'h0) begin
                  alanes_d = nlanes;
                  rem_d    = rem_q & ~nlanes;
                  haddr_d  = {addr_q, lane_off(nlanes)};
                  hsize_d  = lane_size(nlanes);
                  htrans_d = HT_NONSEQ;
                  state_d  = S_ADDR_DATA;
               end else begin
                  htrans_d = HT_IDLE;
                  state_d  = S_DATA;
               end
            end else if (state_q == S_ADDR_DATA && !resp_ok) begin
               htrans_d = HT_IDLE;
               errf_d   = 1'b1;
               state_d  = S_ERR;
            end
         end
         S_DATA: begin
            if (bus.HREADY) begin
               state_d  = S_IDLE;
               rvalid_d = 1'b1;
               rdata_d  = resp_ok ? merged : acc_q;
               err_d    = errf_q | !resp_ok;
            end else if (!resp_ok) begin
               errf_d  = 1'b1;
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            if (bus.HREADY) begin
               state_d  = S_IDLE;
               rvalid_d = 1'b1;
               rdata_d  = acc_q;
               err_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q  <= S_IDLE;  addr_q   <= '0;      we_q     <= 1'b0;
         split_q  <= 1'b0;    rem_q    <= '0;      alanes_q <= '0;
         dlanes_q <= '0;      wdata_q  <= '0;      acc_q    <= '0;
         errf_q   <= 1'b0;    haddr_q  <= '0;      htrans_q <= HT_IDLE;
         hwrite_q <= 1'b0;    hsize_q  <= 3'b010;  hwdata_q <= '0;
         rvalid_q <= 1'b0;    rdata_q  <= '0;      err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;   addr_q   <= addr_d;   we_q     <= we_d;
         split_q  <= split_d;   rem_q    <= rem_d;    alanes_q <= alanes_d;
         dlanes_q <= dlanes_d;  wdata_q  <= wdata_d;  acc_q    <= acc_d;
         errf_q   <= errf_d;    haddr_q  <= haddr_d;  htrans_q <= htrans_d;
         hwrite_q <= hwrite_d;  hsize_q  <= hsize_d;  hwdata_q <= hwdata_d;
         rvalid_q <= rvalid_d;  rdata_q  <= rdata_d;  err_q    <= err_d;
      end
   end

   assign bus.gnt_o    = HRESETn & (state_q == S_IDLE);
   assign bus.HADDR    = haddr_q;
   assign bus.HTRANS   = htrans_q;
   assign bus.HWRITE   = hwrite_q;
   assign bus.HSIZE    = hsize_q;
   assign bus.HBURST   = 3'b000;
   assign bus.HWDATA   = hwdata_q;
   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = rdata_q;
   assign bus.err_o    = err_q;

   a_htrans_legal: assert property (@(posedge HCLK) disable iff (!HRESETn)
      (bus.HTRANS == 2'b00) || (bus.HTRANS == 2'b10))
      else $error("RIGOR obi2ahb_master[%0d]: illegal HTRANS", P_MST_ID);

endmodule

// File: tb/tb_obi2ahb_master.sv
// Randomized bench for obi2ahb_master: AHB slave memory with wait/error
// injection, and a word-level reference model of each OBI request.
module tb_obi2ahb_master;
   logic HCLK = 1'b0;
   logic HRESETn;
   always #5 HCLK = ~HCLK;

   obi2ahb_master_if bus();
   obi2ahb_master #(.P_MST_ID(0)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

   typedef struct packed {logic [31:0] a; logic [2:0] sz; logic w;} xfer_t;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int          cyc     = 0;
   logic [31:0] slv_mem [128];
   logic [31:0] ref_mem [128];
   xfer_t       obs_q[$];
   xfer_t       exp_q[$];
   int unsigned cfg_waits;
   bit          err_arm;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   // Expected AHB transfers for one request, straight from the split rule.
   function automatic void plan(input logic [31:0] addr, input logic [3:0] be, input logic we);
      exp_q.delete();
      if (be == 4'hF)      exp_q.push_back('{{addr[31:2], 2'b00}, 3'b010, we});
      else if (be == 4'h3) exp_q.push_back('{{addr[31:2], 2'b00}, 3'b001, we});
      else if (be == 4'hC) exp_q.push_back('{{addr[31:2], 2'b10}, 3'b001, we});
      else
         for (int i = 0; i < 4; i++)
            if (be[i]) exp_q.push_back('{{addr[31:2], 2'(i)}, 3'b000, we});
   endfunction

   initial forever begin
      @(posedge HCLK);
      cyc++;
   end

   // AHB slave: memory, configurable wait states, two-cycle ERROR on demand.
   initial begin : slave
      logic [1:0]  s_trans;
      logic [31:0] s_addr, s_wdata, p_addr, p_wdata, dp_addr;
      logic [2:0]  s_size, p_size, dp_size;
      logic        s_write, s_rst, p_write;
      logic [3:0]  lanes;
      bit          dp_valid, dp_err, dp_write, pa_wait, pd_wait;
      int unsigned waits, estage;
      dp_valid = 0; dp_err = 0; dp_write = 0; pa_wait = 0; pd_wait = 0;
      waits = 0; estage = 0; dp_addr = '0; dp_size = '0;
      bus.HREADY = 1'b1; bus.HRESP = 2'b00; bus.HRDATA = '0;
      forever begin
         @(negedge HCLK);
         s_trans = bus.HTRANS; s_addr = bus.HADDR; s_size = bus.HSIZE;
         s_write = bus.HWRITE; s_wdata = bus.HWDATA; s_rst = HRESETn;
         if (s_rst && pa_wait) begin
            check_eq("haddr_hold", s_addr, p_addr);
            check_eq("htrans_hold", 32'(s_trans), 32'h2);
            check_eq("hsize_hold", 32'(s_size), 32'(p_size));
            check_eq("hwrite_hold", 32'(s_write), 32'(p_write));
         end
         if (s_rst && pd_wait) check_eq("hwdata_hold", s_wdata, p_wdata);
         if (s_rst && dp_valid && dp_err && estage == 2)
            check_eq("err_htrans_idle", 32'(s_trans), 32'h0);
         pa_wait = s_rst && s_trans == 2'b10 && !bus.HREADY && bus.HRESP == 2'b00;
         pd_wait = s_rst && dp_valid && dp_write && !bus.HREADY && bus.HRESP == 2'b00;
         p_addr = s_addr; p_size = s_size; p_write = s_write; p_wdata = s_wdata;
         @(posedge HCLK);
         #1;
         if (!s_rst) begin
            dp_valid = 0;
         end else if (bus.HREADY) begin
            if (dp_valid && dp_write && !dp_err) begin
               if (dp_size == 3'b010)      lanes = 4'hF;
               else if (dp_size == 3'b001) lanes = dp_addr[1] ? 4'hC : 4'h3;
               else                        lanes = 4'h1 << dp_addr[1:0];
               slv_mem[dp_addr[8:2]] = (slv_mem[dp_addr[8:2]] & ~be_mask(lanes)) |
                                       (s_wdata & be_mask(lanes));
            end
            dp_valid = 0;
            if (s_trans == 2'b10) begin
               dp_valid = 1; dp_addr = s_addr; dp_size = s_size; dp_write = s_write;
               dp_err = err_arm; err_arm = 0; waits = cfg_waits; estage = 0;
               obs_q.push_back('{s_addr, s_size, s_write});
            end
         end
         bus.HRDATA = $urandom;
         if (!dp_valid) begin
            bus.HREADY = 1'b1; bus.HRESP = 2'b00;
         end else if (waits > 0) begin
            bus.HREADY = 1'b0; bus.HRESP = 2'b00; waits--;
         end else if (dp_err && estage == 0) begin
            bus.HREADY = 1'b0; bus.HRESP = 2'b01; estage = 1;
         end else if (dp_err) begin
            bus.HREADY = 1'b1; bus.HRESP = 2'b01; estage = 2;
         end else begin
            bus.HREADY = 1'b1; bus.HRESP = 2'b00;
            if (!dp_write) bus.HRDATA = slv_mem[dp_addr[8:2]];
         end
      end
   end

   task automatic do_req(input string nm, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input int unsigned waits, input bit err);
      int          t0, lat, idx, n, nexp;
      bit          got_gnt, got_rv;
      logic [31:0] rd;
      logic        er;
      idx = int'(addr[8:2]);
      plan(addr, be, we);
      n = exp_q.size();
      if (n == 0) err = 0;
      lat = 0; rd = '0; er = 1'b0;
      @(posedge HCLK);
      #1;
      cfg_waits = waits; err_arm = err; obs_q.delete();
      bus.req_i = 1'b1; bus.addr_i = addr; bus.we_i = we; bus.be_i = be; bus.wdata_i = wdata;
      got_gnt = 0;
      for (int i = 0; i < 20 && !got_gnt; i++) begin
         @(negedge HCLK);
         if (bus.gnt_o) got_gnt = 1;
      end
      t0 = cyc;
      check_eq({nm, "_gnt"}, 32'(got_gnt), 32'h1);
      @(posedge HCLK);
      #1;
      bus.req_i = 1'b0; bus.addr_i = $urandom; bus.we_i = 1'($urandom);
      bus.be_i = 4'($urandom); bus.wdata_i = $urandom;
      if (!got_gnt) return;
      got_rv = 0;
      for (int i = 0; i < 200 && !got_rv; i++) begin
         @(negedge HCLK);
         if (bus.rvalid_o) begin
            got_rv = 1; lat = cyc - t0; rd = bus.rdata_o; er = bus.err_o;
         end
      end
      check_eq({nm, "_rvalid"}, 32'(got_rv), 32'h1);
      if (!got_rv) return;
      @(negedge HCLK);
      check_eq({nm, "_rvalid_pulse"}, 32'(bus.rvalid_o), 32'h0);
      check_eq({nm, "_err"}, 32'(er), 32'(err));
      if (!err) begin
         check_eq({nm, "_latency"}, 32'(lat), (n == 0) ? 32'd1 : 32'(n + 2 + n * int'(waits)));
         if (!we) check_eq({nm, "_rdata"}, rd, ref_mem[idx] & be_mask(be));
         else     ref_mem[idx] = (ref_mem[idx] & ~be_mask(be)) | (wdata & be_mask(be));
      end
      check_eq({nm, "_mem"}, slv_mem[idx], ref_mem[idx]);
      nexp = err ? 1 : n;
      check_eq({nm, "_nxfer"}, 32'(obs_q.size()), 32'(nexp));
      for (int i = 0; i < nexp && i < obs_q.size(); i++) begin
         check_eq({nm, "_haddr"}, obs_q[i].a, exp_q[i].a);
         check_eq({nm, "_hsize"}, 32'(obs_q[i].sz), 32'(exp_q[i].sz));
         check_eq({nm, "_hwrite"}, 32'(obs_q[i].w), 32'(exp_q[i].w));
      end
      err_arm = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      for (int i = 0; i < 128; i++) begin
         slv_mem[i] = $urandom;
         ref_mem[i] = slv_mem[i];
      end
      cfg_waits = 0; err_arm = 0;
      HRESETn = 1'b0;
      bus.req_i = 1'b0; bus.addr_i = '0; bus.we_i = 1'b0; bus.be_i = '0; bus.wdata_i = '0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      check_eq("rst_htrans", 32'(bus.HTRANS), 32'h0);
      check_eq("rst_haddr", bus.HADDR, 32'h0);
      check_eq("rst_hwrite", 32'(bus.HWRITE), 32'h0);
      check_eq("rst_hsize", 32'(bus.HSIZE), 32'h2);
      check_eq("rst_hburst", 32'(bus.HBURST), 32'h0);
      check_eq("rst_hwdata", bus.HWDATA, 32'h0);
      check_eq("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      check_eq("rst_rdata", bus.rdata_o, 32'h0);
      check_eq("rst_err", 32'(bus.err_o), 32'h0);
      check_eq("rst_gnt", 32'(bus.gnt_o), 32'h0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      @(negedge HCLK);
      check_eq("gnt_after_rst", 32'(bus.gnt_o), 32'h1);

      slv_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
      do_req("word_rd", 32'h40, 1'b0, 4'hF, 32'h0, 0, 0);
      slv_mem[32] = 32'h12345678; ref_mem[32] = 32'h12345678;
      do_req("hw_wr", 32'h80, 1'b1, 4'hC, 32'hAABB0000, 0, 0);
      check_eq("hw_wr_value", slv_mem[32], 32'hAABB5678);
      slv_mem[64] = 32'h11223344; ref_mem[64] = 32'h11223344;
      do_req("split_wr", 32'h100, 1'b1, 4'h6, 32'h00CCDD00, 0, 0);
      check_eq("split_wr_value", slv_mem[64], 32'h11CCDD44);
      do_req("wait_rd", 32'h104, 1'b0, 4'h7, 32'h0, 3, 0);
      do_req("err_rd", 32'h108, 1'b0, 4'hE, 32'h0, 0, 1);
      do_req("be0", 32'h10C, 1'b0, 4'h0, 32'h0, 0, 0);
      do_req("be0_wr", 32'h10C, 1'b1, 4'h0, 32'hFFFFFFFF, 0, 0);

      // Reset while the split request sits in its overlapped phase.
      @(posedge HCLK);
      #1;
      cfg_waits = 0;
      bus.req_i = 1'b1; bus.addr_i = 32'h200; bus.we_i = 1'b0; bus.be_i = 4'h6;
      @(negedge HCLK);
      check_eq("mrst_gnt", 32'(bus.gnt_o), 32'h1);
      @(posedge HCLK);
      #1;
      bus.req_i = 1'b0;
      @(posedge HCLK);
      #1;
      HRESETn = 1'b0;
      @(negedge HCLK);
      check_eq("mrst_pre_htrans", 32'(bus.HTRANS), 32'h2);
      @(negedge HCLK);
      check_eq("mrst_htrans", 32'(bus.HTRANS), 32'h0);
      check_eq("mrst_rvalid", 32'(bus.rvalid_o), 32'h0);
      check_eq("mrst_gnt_low", 32'(bus.gnt_o), 32'h0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      @(negedge HCLK);
      check_eq("mrst_gnt_release", 32'(bus.gnt_o), 32'h1);
      for (int i = 0; i < 4; i++) begin
         @(negedge HCLK);
         check_eq("mrst_no_rvalid", 32'(bus.rvalid_o), 32'h0);
      end
      obs_q.delete();

      for (int k = 0; k < 80; k++) begin
         int unsigned w;
         a = $urandom;
         w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         do_req("rnd", a, 1'($urandom), 4'($urandom_range(0, 15)), $urandom, w,
                ($urandom_range(0, 7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
